// File: rtl/rps_match_referee_if.sv
// Handshake and score-display bundle between the round judge / display and
// the match referee. The master side feeds results; the slave side is the referee.
interface rps_match_referee_if;
  logic       start;
  logic       result_valid;
  logic [1:0] result;
  logic       result_ready;
  logic [3:0] user_score;
  logic [3:0] cpu_score;
  logic [3:0] round_cnt;
  logic       busy;
  logic       match_done;
  logic [1:0] match_winner;
  logic       bad_code;

  modport master (
    output start, result_valid, result,
    input  result_ready, user_score, cpu_score, round_cnt,
           busy, match_done, match_winner, bad_code
  );

  modport slave (
    input  start, result_valid, result,
    output result_ready, user_score, cpu_score, round_cnt,
           busy, match_done, match_winner, bad_code
  );
endinterface

// File: rtl/rps_match_referee.sv
// Rock-paper-scissors match scorekeeper: counts round results from the judge and
// declares a winner on reaching WINS_TO_TAKE wins or on exhausting MAX_ROUNDS.
module rps_match_referee #(
  parameter int WINS_TO_TAKE = 2,
  parameter int MAX_ROUNDS   = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  rps_match_referee_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] WIN_CNT = 4'(WINS_TO_TAKE);
  localparam logic [3:0] MAX_CNT = 4'(MAX_ROUNDS);

  logic [1:0] state_q, state_d;
  logic [3:0] user_score_q, user_score_d;
  logic [3:0] cpu_score_q, cpu_score_d;
  logic [3:0] round_cnt_q, round_cnt_d;
  logic [1:0] match_winner_q, match_winner_d;
  logic       match_done_q, match_done_d;
  logic       bad_code_q, bad_code_d;

  logic result_ready;
  logic accept;

  assign result_ready = (state_q == PLAY) && !bus.start;
  assign accept       = bus.result_valid && result_ready;

  always_comb begin
    state_d        = state_q;
    user_score_d   = user_score_q;
    cpu_score_d    = cpu_score_q;
    round_cnt_d    = round_cnt_q;
    match_winner_d = match_winner_q;
    bad_code_d     = bad_code_q;
    match_done_d   = 1'b0;

    case (state_q)
      IDLE, DONE, PLAY: begin
        if (bus.start) begin
          state_d        = PLAY;
          user_score_d   = 4'd0;
          cpu_score_d    = 4'd0;
          round_cnt_d    = 4'd0;
          match_winner_d = 2'b00;
          bad_code_d     = 1'b0;
        end else if (accept && bus.result == 2'b10) begin
          bad_code_d = 1'b1;
        end else if (accept) begin
          // End checks use the post-increment counts of this same accept.
          if (bus.result == 2'b00) user_score_d = user_score_q + 4'd1;
          if (bus.result == 2'b11) cpu_score_d  = cpu_score_q + 4'd1;
          round_cnt_d = round_cnt_q + 4'd1;
          if (user_score_d == WIN_CNT) begin
            match_winner_d = 2'b00;
            state_d        = DONE;
            match_done_d   = 1'b1;
          end else if (cpu_score_d == WIN_CNT) begin
            match_winner_d = 2'b11;
            state_d        = DONE;
            match_done_d   = 1'b1;
          end else if (round_cnt_d == MAX_CNT) begin
            if (user_score_d > cpu_score_d)      match_winner_d = 2'b00;
            else if (cpu_score_d > user_score_d) match_winner_d = 2'b11;
            else                                 match_winner_d = 2'b01;
            state_d      = DONE;
            match_done_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      user_score_q   <= 4'd0;
      cpu_score_q    <= 4'd0;
      round_cnt_q    <= 4'd0;
      match_winner_q <= 2'b00;
      match_done_q   <= 1'b0;
      bad_code_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      user_score_q   <= user_score_d;
      cpu_score_q    <= cpu_score_d;
      round_cnt_q    <= round_cnt_d;
      match_winner_q <= match_winner_d;
      match_done_q   <= match_done_d;
      bad_code_q     <= bad_code_d;
    end
  end

  assign bus.result_ready = result_ready;
  assign bus.user_score   = user_score_q;
  assign bus.cpu_score    = cpu_score_q;
  assign bus.round_cnt    = round_cnt_q;
  assign bus.busy         = (state_q == PLAY);
  assign bus.match_done   = match_done_q;
  assign bus.match_winner = match_winner_q;
  assign bus.bad_code     = bad_code_q;

endmodule

// File: doc/rps_match_referee.md
# rps_match_referee

Match-level scorekeeper for the rock-paper-scissors game. It consumes the per-round result codes that the round judge produces (00 user wins, 01 draw, 11 computer wins) and tracks the user and computer scores. It declares a match winner when one side reaches a configurable win count, or when a round limit expires. It sits downstream of the round judge and drives the score display and match-over indication.

## Interface
Parameters:
- WINS_TO_TAKE, 2 — round wins needed to take the match (2 = best of 3); legal range 1..15.
- MAX_ROUNDS, 9 — total accepted rounds, draws included, after which the match is forced to end; legal range WINS_TO_TAKE..15.

Ports:
- clk  in  1  — single clock; all logic on rising edge.
- reset  in  1  — synchronous, active-low reset.
- start  in  1  — begin or restart a match; level sampled each cycle.
- result_valid  in  1  — round result present on result.
- result  in  2  — round code: 00 user win, 01 draw, 11 computer win, 10 illegal.
- result_ready  out  1  — block accepts a result this cycle.
- user_score  out  4  — user round wins in the current or last match.
- cpu_score  out  4  — computer round wins in the current or last match.
- round_cnt  out  4  — legal rounds accepted in the current match.
- busy  out  1  — match in progress.
- match_done  out  1  — one-cycle pulse when the match ends.
- match_winner  out  2  — 00 user, 01 tie, 11 computer; valid from match_done onward.
- bad_code  out  1  — sticky flag: an illegal code (10) was accepted during this match.

## Operation
- FSM states:
  - IDLE: after reset; waits for start.
  - PLAY: collects round results.
  - DONE: holds the final result.
- Accept = result_valid & result_ready.
- result_ready = 1 only in PLAY and only when start = 0.
- IDLE or DONE, start = 1:
  - Next cycle: user_score, cpu_score, round_cnt, bad_code and match_winner cleared to 0; state goes to PLAY.
  - match_winner is cleared to 00, which is not meaningful until the next match_done.
- PLAY, start = 1: the match restarts with the same clears. Any simultaneous result is not accepted, because result_ready is 0.
- PLAY, accept, by result code:
  - 00: user_score +1, round_cnt +1.
  - 11: cpu_score +1, round_cnt +1.
  - 01: round_cnt +1 only.
  - 10: no count change; bad_code set to 1.
- End-of-match checks, evaluated on the post-increment values of the same accept:
  - User score reaches WINS_TO_TAKE: winner 00, go to DONE.
  - Computer score reaches WINS_TO_TAKE: winner 11, go to DONE.
  - Otherwise, round_cnt reaches MAX_ROUNDS: winner is the higher score (user 00, computer 11), or 01 if scores are equal; go to DONE.
  - Only one score can change per accept, so the two win conditions are mutually exclusive.
- Score width: counters never exceed WINS_TO_TAKE or MAX_ROUNDS, so no wrap is possible. The 4-bit outputs are zero-extended.
- DONE:
  - Scores, round_cnt, match_winner and bad_code hold.
  - result_valid is ignored.
  - Stays in DONE until start.
- busy = 1 exactly in PLAY.

## Timing
- Reset values, applied at a clk edge with reset = 0:
  - state IDLE.
  - user_score 0, cpu_score 0, round_cnt 0.
  - match_winner 00, match_done 0, bad_code 0, busy 0, result_ready 0.
- Reset asserted mid-match aborts the match. No match_done is generated.
- Start latency: start sampled high at edge N → busy = 1 and result_ready = 1 (if start is low) from cycle N+1.
- Result latency: accept at edge N → updated scores and round_cnt visible in cycle N+1.
- Decisive accept at edge N, in cycle N+1:
  - match_done = 1, for that cycle only.
  - match_winner is valid.
  - busy = 0 and result_ready = 0.
- Back-to-back accepts: one accept per cycle at full rate.
- Start held high continuously: the block remains in PLAY with cleared counters and never accepts a result.

## Test plan
- Reset, then start pulse, then results 00, 00 on consecutive cycles:
  - Cycle after the second accept: user_score = 2, cpu_score = 0, match_done pulse, match_winner = 00, busy = 0.
- Results 11, 01, 00, 11 with WINS_TO_TAKE = 2:
  - round_cnt = 4, cpu_score = 2, user_score = 1, match_winner = 11.
- MAX_ROUNDS = 3, results 01, 00, 11:
  - Forced end: match_winner = 01, round_cnt = 3, one match_done pulse.
- Result 10 mid-match:
  - Counts unchanged, bad_code = 1.
  - bad_code clears on the next start.
- start asserted during PLAY with result_valid = 1, result = 00:
  - result_ready = 0, result not counted.
  - Next cycle all counters are 0 and busy = 1.
- After DONE: result_valid pulses are ignored and scores hold.
  - Reset low in the middle of a subsequent match → all outputs return to reset values, with no match_done.
